pwm_meas: RTL and testbench
===========================

Name: pwm_meas

Overview:
- Measures an incoming PWM waveform. It is the receiving counterpart of the board's PWM generator.
- Reports the period and high time of each complete cycle, in CLK cycles.
- Sits at the top level beside the PWM generator, on CLOCK_50. Typical input is a GPIO pin, or a loopback of the generator's LED output for self-test.
- Flags a stuck-high or stuck-low input with a timeout.

Parameters:
- CNT_W, 24, width of the cycle counter and of the PERIOD and HIGH outputs.
- TIMEOUT, 5000000, cycles without a qualifying edge before the timeout fires (100 ms at 50 MHz). Must satisfy 2 <= TIMEOUT < 2^CNT_W-1.

Ports:
- CLK  input  1  system clock (CLOCK_50).
- RST_N  input  1  reset; asynchronous assert, active-low.
- PWM_IN  input  1  asynchronous PWM input.
- PERIOD  output  CNT_W  last measured period, in cycles.
- HIGH  output  CNT_W  last measured high time, in cycles.
- VALID  output  1  one-cycle pulse when PERIOD and HIGH update.
- TIMEOUT_F  output  1  set when the input is stuck; cleared by the next VALID.
- LEVEL  output  1  synchronized input level.

Behaviour:
- Clock and reset: one clock, CLK. Reset RST_N is asynchronous and active-low.
- Reset values: PERIOD=0, HIGH=0, VALID=0, TIMEOUT_F=0, LEVEL=0, state IDLE, cnt=0, hcap=0, sync flops=0. Asserting reset mid-measurement aborts it; nothing is reported.
- Front end: 2-FF synchronizer, then a registered previous-level flop.
  - rise = s & ~s_d; fall = ~s & s_d.
  - Edge-detect latency from a PWM_IN transition is 3 cycles.
  - LEVEL = s.
- Counter:
  - In the cycle rise is asserted, cnt <= 1.
  - Otherwise cnt increments each cycle while not in IDLE.
  - cnt saturates at all-ones; TIMEOUT keeps it below that.
- State machine:
  - IDLE: cnt held at 0. On rise -> HIGH_PH.
  - HIGH_PH: on fall, hcap <= cnt, -> LOW_PH. On rise (unreachable after the synchronizer), treat as in LOW_PH.
  - LOW_PH: on rise:
    - PERIOD <= cnt, HIGH <= hcap, VALID <= 1 for one cycle, TIMEOUT_F <= 0;
    - cnt <= 1; stay in the measuring flow -> HIGH_PH.
  - Timeout: in HIGH_PH or LOW_PH, if cnt == TIMEOUT and no edge this cycle:
    - -> IDLE, TIMEOUT_F <= 1, PERIOD <= 0, HIGH <= 0, no VALID.
    - LEVEL then tells the user stuck-high from stuck-low.
- Result for a waveform high H cycles and low L cycles (after sync): PERIOD = H+L, HIGH = H.
  - Minimum measurable values: H >= 1, L >= 1.
  - VALID fires 3 cycles after the PWM_IN rising edge that closes the cycle.
- First cycle after reset or timeout: no VALID. The first VALID follows the second observed rising edge.
- Boundary conditions:
  - Edge and cnt==TIMEOUT in the same cycle: the edge wins, normal processing, no timeout.
  - A constant input from reset never leaves IDLE, so TIMEOUT_F stays 0. The timeout applies only after a first rising edge.
  - 0% or 100% duty after running: timeout fires TIMEOUT cycles after the last edge.
- Outputs are registered and hold their value between VALID pulses.

Decomposition:
- Shared package pwm_pkg:
  - state enum (IDLE, HIGH_PH, LOW_PH);
  - default CNT_W;
  - localparam CLK_HZ = 50_000_000, shared with the PWM generator.
- Sub-module sync_edge (CLK, RST_N, D, Q, RISE, FALL): holds the 2-FF synchronizer plus edge detect; reusable for KEY/SW inputs.
- Top level instantiates pwm_meas with RST_N = KEY[3] and PWM_IN driven from a GPIO_0 pin.

Test Plan:
- Reset, then PWM H=30, L=70, repeated 5 times -> first VALID after the 2nd rise with PERIOD=100, HIGH=30; VALID once per cycle thereafter, 3 cycles after each rise.
- Duty step: H=10, L=90, then H=90, L=10 -> PERIOD=100 throughout; HIGH reads 10 until the first cycle at the new duty completes, then 90.
- TIMEOUT=1000; run H=L=50, then hold PWM_IN high -> TIMEOUT_F=1 exactly 1000 cycles after the counter restart, PERIOD=HIGH=0, LEVEL=1, no VALID; resume the waveform -> TIMEOUT_F clears on the next VALID.
- Minimum pulse: H=1, L=1 -> PERIOD=2, HIGH=1 every 2 cycles.
- Assert RST_N low mid-HIGH_PH -> all outputs return to 0 immediately (asynchronously); no VALID until two rises after reset release.
- Edge coincident with cnt==TIMEOUT (TIMEOUT=100, H=40, L=60) -> VALID with PERIOD=100, HIGH=40, TIMEOUT_F stays 0.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator / measurement pair.
package pwm_pkg;

    // Board system clock, shared with the PWM generator.
    localparam int unsigned CLK_HZ      = 50_000_000;

    // Default counter width for PERIOD / HIGH (2^24 cycles ~ 335 ms at 50 MHz).
    localparam int unsigned CNT_W_DEF   = 24;

    // Default stuck-input timeout: 100 ms at CLK_HZ.
    localparam int unsigned TIMEOUT_DEF = CLK_HZ / 10;

    // Measurement FSM states.
    typedef enum logic [1:0] {
        StIdle,
        StHighPh,
        StLowPh
    } meas_state_e;

endpackage

// File: rtl/sync_edge.sv
// 2-FF synchronizer followed by a previous-level flop for edge detection.
// Reusable for any asynchronous single-bit input (PWM pins, KEY, SW).
module sync_edge (
    input  logic CLK,
    input  logic RST_N,
    input  logic D,
    output logic Q,
    output logic RISE,
    output logic FALL
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchronizer chain plus one-cycle-delayed copy of the synchronized level.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= D;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign Q    = sync_q;
    assign RISE = sync_q & ~prev_q;
    assign FALL = ~sync_q & prev_q;

endmodule

// File: rtl/pwm_meas.sv
// PWM measurement: reports period and high time of each complete input cycle
// in CLK cycles, and flags a stuck input after TIMEOUT cycles without an edge.
module pwm_meas
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             PWM_IN,
    output logic [CNT_W-1:0] PERIOD,
    output logic [CNT_W-1:0] HIGH,
    output logic             VALID,
    output logic             TIMEOUT_F,
    output logic             LEVEL
);

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntTo  = CNT_W'(TIMEOUT);

    logic        lvl;
    logic        rise;
    logic        fall;

    meas_state_e     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] hcap_q;

    sync_edge u_sync_edge (
        .CLK   (CLK),
        .RST_N (RST_N),
        .D     (PWM_IN),
        .Q     (lvl),
        .RISE  (rise),
        .FALL  (fall)
    );

    assign LEVEL = lvl;

    // Measurement FSM with cycle counter, high-time capture and registered results.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            hcap_q    <= '0;
            PERIOD    <= '0;
            HIGH      <= '0;
            VALID     <= 1'b0;
            TIMEOUT_F <= 1'b0;
        end else begin
            VALID <= 1'b0;

            // Counter: restart on every rise, otherwise count (saturating) while measuring.
            if (rise) begin
                cnt_q <= CntOne;
            end else if (state_q != StIdle && cnt_q != CntMax) begin
                cnt_q <= cnt_q + CntOne;
            end

            unique case (state_q)
                StIdle: begin
                    cnt_q <= rise ? CntOne : '0;
                    if (rise) begin
                        state_q <= StHighPh;
                    end
                end

                StHighPh, StLowPh: begin
                    if (rise) begin
                        // A rise closes a full cycle; a rise seen in the high phase
                        // cannot occur after the synchronizer and is handled alike.
                        PERIOD    <= cnt_q;
                        HIGH      <= hcap_q;
                        VALID     <= 1'b1;
                        TIMEOUT_F <= 1'b0;
                        state_q   <= StHighPh;
                    end else if (fall && state_q == StHighPh) begin
                        hcap_q  <= cnt_q;
                        state_q <= StLowPh;
                    end else if (!fall && cnt_q == CntTo) begin
                        // No edge for TIMEOUT cycles: input is stuck, abandon the cycle.
                        state_q   <= StIdle;
                        cnt_q     <= '0;
                        TIMEOUT_F <= 1'b1;
                        PERIOD    <= '0;
                        HIGH      <= '0;
                    end
                end

                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_meas.sv
// Self-checking bench for pwm_meas: two instances (TIMEOUT=100 and 1000) share
// one PWM stimulus; a time-stamp based reference model predicts every output.
module tb_pwm_meas;

    localparam int unsigned CW   = 16;
    localparam int unsigned TO_A = 100;
    localparam int unsigned TO_B = 1000;
    localparam longint      CMAX = 65535;

    logic clk = 1'b0;
    logic rst_n;
    logic pwm_in;

    logic [CW-1:0] period [2];
    logic [CW-1:0] high   [2];
    logic          valid  [2];
    logic          tf     [2];
    logic          level  [2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pwm_meas #(.CNT_W(CW), .TIMEOUT(TO_A)) dut_a (
        .CLK       (clk),
        .RST_N     (rst_n),
        .PWM_IN    (pwm_in),
        .PERIOD    (period[0]),
        .HIGH      (high[0]),
        .VALID     (valid[0]),
        .TIMEOUT_F (tf[0]),
        .LEVEL     (level[0])
    );

    pwm_meas #(.CNT_W(CW), .TIMEOUT(TO_B)) dut_b (
        .CLK       (clk),
        .RST_N     (rst_n),
        .PWM_IN    (pwm_in),
        .PERIOD    (period[1]),
        .HIGH      (high[1]),
        .VALID     (valid[1]),
        .TIMEOUT_F (tf[1]),
        .LEVEL     (level[1])
    );

    // Reference model: remembers when the last rise/fall was seen, derives
    // period and high time as time differences.
    bit     armed    [2];
    bit     phase_hi [2];
    longint t_rise   [2];
    longint t_fall   [2];
    longint e_period [2];
    longint e_high   [2];
    bit     e_valid  [2];
    bit     e_tf     [2];
    bit     e_lvl;
    bit     h0, h1, h2;   // driven input one, two, three edges ago
    longint cyc = 0;

    function automatic longint to_of(int i);
        return (i == 0) ? longint'(TO_A) : longint'(TO_B);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            armed[i] = 0; phase_hi[i] = 0; t_rise[i] = 0; t_fall[i] = 0;
            e_period[i] = 0; e_high[i] = 0; e_valid[i] = 0; e_tf[i] = 0;
        end
        e_lvl = 0; h0 = 0; h1 = 0; h2 = 0;
    endtask

    task automatic model_step(int i, bit s, bit sd, longint n);
        longint el;
        el = n - t_rise[i];
        if (el > CMAX) el = CMAX;
        e_valid[i] = 0;
        if (s && !sd) begin
            if (armed[i] && !phase_hi[i]) begin
                e_period[i] = el;
                e_high[i]   = t_fall[i] - t_rise[i];
                e_valid[i]  = 1;
                e_tf[i]     = 0;
            end
            armed[i] = 1; phase_hi[i] = 1; t_rise[i] = n;
        end else if (!s && sd) begin
            if (armed[i] && phase_hi[i]) begin
                t_fall[i] = n; phase_hi[i] = 0;
            end
        end else if (armed[i] && el == to_of(i)) begin
            armed[i] = 0; e_tf[i] = 1; e_period[i] = 0; e_high[i] = 0;
        end
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("valid[%0d]", i),  32'(valid[i]),  32'(e_valid[i]));
            check($sformatf("period[%0d]", i), 32'(period[i]), 32'(e_period[i]));
            check($sformatf("high[%0d]", i),   32'(high[i]),   32'(e_high[i]));
            check($sformatf("tmo[%0d]", i),    32'(tf[i]),     32'(e_tf[i]));
            check($sformatf("level[%0d]", i),  32'(level[i]),  32'(e_lvl));
        end
    endtask

    // One clock: drive input, let the edge happen, advance model, compare.
    task automatic tick(bit v);
        pwm_in = v;
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) model_step(i, h1, h2, cyc);
        e_lvl = h0;
        h2 = h1; h1 = h0; h0 = v;
        #1;
        compare_all();
    endtask

    task automatic pwm(int h, int l, int reps);
        for (int r = 0; r < reps; r++) begin
            repeat (h) tick(1'b1);
            repeat (l) tick(1'b0);
        end
    endtask

    task automatic hold(bit v, int n);
        repeat (n) tick(v);
    endtask

    // Asynchronous reset: outputs must clear without waiting for a clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_period", 32'(period[i]), 32'd0);
            check("rst_high",   32'(high[i]),   32'd0);
            check("rst_valid",  32'(valid[i]),  32'd0);
            check("rst_tmo",    32'(tf[i]),     32'd0);
            check("rst_level",  32'(level[i]),  32'd0);
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int h, l;
        rst_n  = 1'b1;
        pwm_in = 1'b0;
        model_reset();
        #2;
        do_reset();

        // Constant low from reset: stays idle, no timeout.
        hold(1'b0, 1200);
        check("idle_no_tmo", 32'(tf[1]), 32'd0);

        // Basic 30/70 waveform.
        pwm(30, 70, 5);
        check("dir_period_3070", 32'(period[1]), 32'd100);
        check("dir_high_3070",   32'(high[1]),   32'd30);

        // Duty step.
        pwm(10, 90, 3);
        pwm(90, 10, 3);
        check("dir_high_step", 32'(high[1]), 32'd90);

        // Edge coincident with cnt==TIMEOUT on the TIMEOUT=100 instance.
        pwm(40, 60, 4);
        check("dir_coinc_tmo", 32'(tf[0]), 32'd0);
        check("dir_coinc_high", 32'(high[0]), 32'd40);

        // Stuck high, then resume.
        pwm(50, 50, 3);
        hold(1'b1, 1100);
        check("dir_stuck_hi_tmo",   32'(tf[1]),     32'd1);
        check("dir_stuck_hi_level", 32'(level[1]),  32'd1);
        check("dir_stuck_hi_per",   32'(period[1]), 32'd0);
        pwm(50, 50, 3);
        check("dir_resume_tmo", 32'(tf[1]), 32'd0);

        // Stuck low.
        hold(1'b0, 1100);
        check("dir_stuck_lo_tmo",   32'(tf[1]),    32'd1);
        check("dir_stuck_lo_level", 32'(level[1]), 32'd0);

        // Minimum pulse widths.
        pwm(1, 1, 12);
        check("dir_min_period", 32'(period[1]), 32'd2);
        check("dir_min_high",   32'(high[1]),   32'd1);

        // Reset in the middle of a high phase.
        pwm(20, 20, 2);
        hold(1'b1, 10);
        do_reset();
        pwm(20, 20, 3);

        // Randomized waveforms.
        for (int k = 0; k < 60; k++) begin
            h = int'($urandom_range(1, 150));
            l = int'($urandom_range(1, 150));
            pwm(h, l, 1);
        end
        pwm(5, 5, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
